// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the RISC-V integer register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned MAX_REGS = 256;

  function automatic int unsigned addr_w(input int unsigned nregs);
    return (nregs < 2) ? 1 : 32'($clog2(nregs));
  endfunction

  function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MAX_REGS; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: RAW/WAW hazard detection, busy vector and pending count.
// Honours REGFILE_BYPASS_EN (a retiring producer does not stall its consumer).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NREGS  = 32,
  parameter  int unsigned NRD    = 2,
  localparam int unsigned ADDR_W = addr_w(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic                  issue_valid,
  input  logic [ADDR_W-1:0]     issue_rd,
  input  logic                  issue_rd_en,
  input  logic [NRD*ADDR_W-1:0] issue_rs,
  input  logic [NRD-1:0]        issue_rs_en,
  input  logic                  flush,
  output logic                  stall,
  output logic [NREGS-1:0]      busy,
  output logic [ADDR_W:0]       pending_cnt
);

  logic              hazard;
  logic              waw;
  logic              accept;
  logic [ADDR_W-1:0] rs;
  logic [NREGS-1:0]  busy_nxt;

  // Hazard check and next busy vector; a set on the same register beats a clear.
  always_comb begin
    hazard = 1'b0;
    rs     = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rs = issue_rs[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      if (issue_rs_en[i] && busy[rs] && (rs != '0) && !(we && (waddr == rs))) hazard = 1'b1;
`else
      if (issue_rs_en[i] && busy[rs] && (rs != '0)) hazard = 1'b1;
`endif
    end
    waw    = issue_rd_en && busy[issue_rd] && (issue_rd != '0) && !(we && (waddr == issue_rd));
    stall  = !reset && issue_valid && !flush && (hazard || waw);
    accept = issue_valid && !stall && !flush;

    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (we) busy_nxt[waddr] = 1'b0;
      if (accept && issue_rd_en && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_nxt;
      pending_cnt <= (ADDR_W+1)'(popcount(MAX_REGS'(busy_nxt)));
    end
  end

endmodule

// File: rtl/rv_regfile.sv
// RISC-V integer register file: x0 hardwired to zero, NRD read ports, one write port.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module rv_regfile
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREGS  = 32,
  parameter  int unsigned NRD    = 2,
  localparam int unsigned ADDR_W = addr_w(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*XLEN-1:0]   rdata,
  input  logic                  issue_valid,
  input  logic [ADDR_W-1:0]     issue_rd,
  input  logic                  issue_rd_en,
  input  logic [NRD*ADDR_W-1:0] issue_rs,
  input  logic [NRD-1:0]        issue_rs_en,
  input  logic                  flush,
  output logic                  stall,
  output logic [NREGS-1:0]      busy,
  output logic [ADDR_W:0]       pending_cnt
);

  logic [XLEN-1:0]   regs [NREGS];
  logic [ADDR_W-1:0] ra;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read mux; x0 forced to zero regardless of array contents.
  always_comb begin
    rdata = '0;
    ra    = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      ra = raddr[i*ADDR_W +: ADDR_W];
      rdata[i*XLEN +: XLEN] = (ra == '0) ? '0 : regs[ra];
`ifdef REGFILE_BYPASS_EN
      if (!reset && we && (waddr == ra) && (ra != '0)) rdata[i*XLEN +: XLEN] = wdata;
`endif
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .waddr       (waddr),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rd_en (issue_rd_en),
    .issue_rs    (issue_rs),
    .issue_rs_en (issue_rs_en),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .pending_cnt (pending_cnt)
  );

endmodule

// File: doc/rv_regfile.md
# rv_regfile

Parametrised integer register file for the RISC-V datapath, with multi-port read, one write port, optional write-to-read bypass and an integrated busy-bit scoreboard. It sits between decode (issue) and writeback: decode reads operands and checks hazards, writeback writes results and retires pending destinations. Register 0 is hardwired to zero.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2)
- NRD, 2, number of read ports (1..4)
- ADDR_W, $clog2(NREGS), derived local parameter; not overridable

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- we  in  1  writeback write enable
- waddr  in  ADDR_W  writeback destination
- wdata  in  XLEN  writeback data
- raddr  in  NRD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- issue_valid  in  1  decode presents an instruction
- issue_rd  in  ADDR_W  destination of issuing instruction
- issue_rd_en  in  1  instruction writes a register
- issue_rs  in  NRD*ADDR_W  source registers checked for hazards
- issue_rs_en  in  NRD  per-source check enable
- flush  in  1  clears all busy bits (pipeline flush)
- stall  out  1  issue must be held
- busy  out  NREGS  current busy vector
- pending_cnt  out  ADDR_W+1  number of set busy bits

## Operation
- Storage: NREGS x XLEN array; all entries 0 on reset.
- Write: at rising edge with we=1 and waddr≠0, reg[waddr] <= wdata. Writes to 0 are discarded.
- Read: combinational; raddr=0 always returns 0.
- Scoreboard, evaluated per cycle:
  - hazard_i = issue_rs_en[i] & busy[rs_i] & (rs_i≠0), masked when bypass clears it (see Configuration).
  - waw = issue_rd_en & busy[issue_rd] & (issue_rd≠0) & !(we & waddr==issue_rd).
  - stall = issue_valid & !flush & (any hazard_i | waw).
  - Accepted issue = issue_valid & !stall & !flush.
  - Next busy: clear bit waddr if we; then set bit issue_rd on accepted issue with issue_rd_en and issue_rd≠0. Same register cleared and set in the same cycle → set wins.
  - flush=1: all busy bits cleared next edge; issue and we-clears ignored that cycle (the register write itself still occurs).
- busy[0] is constant 0.
- pending_cnt: registered population count of the next busy vector; range 0..NREGS-1.

## Timing
- Reset (async assert, sync-safe release): registers 0, busy 0, pending_cnt 0, stall 0, rdata 0.
- Write latency: a value written at edge N is visible on rdata from N onward (after edge), combinationally.
- Same-cycle write and read of same address: the old value without bypass, wdata with bypass.
- busy/pending_cnt update at the edge following an accepted issue or a writeback; stall is combinational from the current busy vector and inputs.
- Reset asserted mid-operation discards all pending state; no stall asserted during reset.

## Configuration
- REGFILE_BYPASS_EN defined: rdata port i returns wdata when we & waddr==raddr_i & raddr_i≠0; hazard_i suppressed when we & waddr==rs_i (producer retires this cycle).
- Undefined: no forwarding; reads return the array value; hazard_i raised while busy regardless of a same-cycle writeback (one extra stall cycle).

## Structure
- Package regfile_pkg: XLEN default, REG_ZERO index constant, addr_w(nregs) function, popcount function.
- One sub-module, regfile_scoreboard: busy vector, stall, pending_cnt; rv_regfile holds the array, read mux and bypass.

## Test plan
- Reset, then read all ports for x0..x31 -> all 0; busy=0, pending_cnt=0.
- Write x5=0xDEADBEEF, next cycle read x5 -> 0xDEADBEEF; write x0=0x1234 -> x0 still reads 0.
- Same-cycle we x7=0xA5A5A5A5 and raddr=7 -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, previous value without.
- Issue rd=3, next cycle issue rs0=3 -> stall=1, busy[3]=1, pending_cnt=1; writeback x3 -> stall drops that cycle (bypass) or next cycle (no bypass).
- Writeback x4 and accepted issue rd=4 same cycle -> busy[4]=1 afterward; issue rd=4 again -> stall (WAW).
- Set busy on x1,x2,x9, assert flush -> busy=0, pending_cnt=0 next cycle; assert reset mid-stall -> stall=0 immediately.
